// File: rtl/led_pkg.sv
// Shared definitions for the switch-to-LED driver: per-channel mode encodings
// and a constant-foldable ceiling log2 used to size counters.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_INV    = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_TOGGLE = 2'b11
    } led_mode_e;

    // Smallest r with 2**r >= value; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchroniser, debounce counter, stable level and change pulse.
// SW_ACTIVE_LOW_EN selects pull-up wiring (flops reset high, pin inverted into sync).
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 16000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic sw,
    output logic sync,
    output logic stable,
    output logic sw_edge
);
    import led_pkg::*;

    localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef SW_ACTIVE_LOW_EN
    localparam logic PIN_IDLE = 1'b1;
`else
    localparam logic PIN_IDLE = 1'b0;
`endif

    logic             pin_meta;
    logic             pin_q;
    logic [CNT_W-1:0] cnt;

    // Flops hold the raw pin level so the idle pin maps to sync == 0 out of reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pin_meta <= PIN_IDLE;
            pin_q    <= PIN_IDLE;
        end else begin
            pin_meta <= sw;
            pin_q    <= pin_meta;
        end
    end

`ifdef SW_ACTIVE_LOW_EN
    assign sync = ~pin_q;
`else
    assign sync = pin_q;
`endif

    // The pulse marks the cycle the new level is accepted; stable follows on the next edge.
    assign sw_edge = (sync != stable) && (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sw_led_driver.sv
// N_CH debounced switches driving LEDs in PASS/INV/BLINK/TOGGLE modes plus a pattern heartbeat.
// Define SW_ACTIVE_LOW_EN for switches wired to ground with pull-ups.
module sw_led_driver #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 16000,
    parameter int PATTERN_W       = 32,
    parameter int STEP_LOG2       = 21
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [N_CH-1:0]        SW,
    input  logic [2*N_CH-1:0]      MODE,
    input  logic [PATTERN_W-1:0]   PATTERN,
    output logic [N_CH-1:0]        LED_BUS,
    output logic                   LED_USER,
    output logic [N_CH-1:0]        SW_STABLE,
    output logic [N_CH-1:0]        SW_EDGE
);
    import led_pkg::*;

    localparam int IDX_W = clog2(PATTERN_W);
    localparam int PH_W  = STEP_LOG2 + IDX_W;

    logic [PH_W-1:0]  ph;
    logic [IDX_W-1:0] idx;
    logic             pat_bit;
    logic [N_CH-1:0]  sync;
    logic [N_CH-1:0]  tog;
    logic [N_CH-1:0]  led_next;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        sw_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .sw      (SW[g]),
            .sync    (sync[g]),
            .stable  (SW_STABLE[g]),
            .sw_edge (SW_EDGE[g])
        );
    end

    assign idx     = ph[PH_W-1 -: IDX_W];
    assign pat_bit = PATTERN[idx];

    // MODE and PATTERN are plain levels sampled on every edge; there is no valid/ready.
    always_comb begin
        led_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (led_mode_e'(MODE[2*i +: 2]))
                MODE_PASS:   led_next[i] = SW_STABLE[i];
                MODE_INV:    led_next[i] = ~SW_STABLE[i];
                MODE_BLINK:  led_next[i] = SW_STABLE[i] & pat_bit;
                MODE_TOGGLE: led_next[i] = tog[i];
                default:     led_next[i] = 1'b0;
            endcase
        end
    end

    // tog runs in every mode so a channel keeps its latch across mode changes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ph       <= '0;
            tog      <= '0;
            LED_BUS  <= '0;
            LED_USER <= 1'b0;
        end else begin
            ph       <= ph + PH_W'(1);
            tog      <= tog ^ (SW_EDGE & sync);
            LED_BUS  <= led_next;
            LED_USER <= pat_bit;
        end
    end

endmodule

// File: tb/tb_sw_led_driver.sv
// Directed bench for sw_led_driver with an edge scoreboard and level checks.
module tb_sw_led_driver;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] SW;
    logic [7:0] MODE;
    logic [7:0] PATTERN;
    logic [3:0] LED_BUS;
    logic       LED_USER;
    logic [3:0] SW_STABLE;
    logic [3:0] SW_EDGE;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_rst    = 0;
    int edge_cyc = -1;
    int start    = 0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_e;

    int blink_seq[8] = '{0, 1, 1, 0, 0, 1, 0, 1};
    int tog_seq[3]   = '{1, 0, 1};

    sw_led_driver #(
        .N_CH            (4),
        .DEBOUNCE_CYCLES (4),
        .PATTERN_W       (8),
        .STEP_LOG2       (2)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .SW        (SW),
        .MODE      (MODE),
        .PATTERN   (PATTERN),
        .LED_BUS   (LED_BUS),
        .LED_USER  (LED_USER),
        .SW_STABLE (SW_STABLE),
        .SW_EDGE   (SW_EDGE)
    );

    // Clock/reset block
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) n_rst <= 0;
        else        n_rst <= n_rst + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: every SW_EDGE pulse must match the head of exp_q
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && SW_EDGE !== 4'b0000) begin
            edge_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sw_edge_unexpected: got %b required no edge", SW_EDGE);
            end else begin
                exp_e = exp_q.pop_front();
                if (SW_EDGE !== exp_e) begin
                    errors++;
                    $display("FAIL sw_edge_vector: got %b required %b", SW_EDGE, exp_e);
                end
            end
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic press(input int ch);
        logic [3:0] v;
        v = 4'b0001 << ch;
        SW[ch] = 1'b1;
        exp_q.push_back(v);
        tick(8);
        SW[ch] = 1'b0;
        exp_q.push_back(v);
        tick(8);
    endtask

    initial begin
        RST_N   = 1'b1;
        SW      = 4'b0000;
        MODE    = 8'h00;
        PATTERN = 8'h00;
        #3 RST_N = 1'b0;
        tick(3);
        check("rst_led_bus",   LED_BUS,   0);
        check("rst_led_user",  LED_USER,  0);
        check("rst_sw_stable", SW_STABLE, 0);
        check("rst_sw_edge",   SW_EDGE,   0);
        RST_N = 1'b1;

        // Idle: nothing moves
        tick(50);
        check("idle_led_bus",   LED_BUS,   0);
        check("idle_led_user",  LED_USER,  0);
        check("idle_sw_stable", SW_STABLE, 0);

        // Clean step on SW[0] in PASS
        SW[0] = 1'b1;
        start = cyc;
        exp_q.push_back(4'b0001);
        tick(4);
        check("s0_not_early", SW_STABLE[0], 0);
        tick(2);
        check("s0_stable", SW_STABLE[0], 1);
        check("led0_lag", LED_BUS[0], 0);
        tick(1);
        check("led0_pass", LED_BUS[0], 1);
        check("edge0_latency", edge_cyc - start, 5);

        // 3-cycle glitch on SW[1] is rejected
        SW[1] = 1'b1;
        tick(3);
        SW[1] = 1'b0;
        tick(12);
        check("glitch_stable1", SW_STABLE[1], 0);

        // 5-cycle hold on SW[1] is accepted, then released
        SW[1] = 1'b1;
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0010);
        tick(5);
        SW[1] = 1'b0;
        tick(1);
        check("hold5_stable1", SW_STABLE[1], 1);
        tick(10);
        check("hold5_release1", SW_STABLE[1], 0);

        // TOGGLE on channel 2
        MODE[5:4] = 2'b11;
        tick(2);
        check("tog_initial", LED_BUS[2], 0);
        for (int k = 0; k < 3; k++) begin
            press(2);
            check($sformatf("tog_press%0d", k), LED_BUS[2], tog_seq[k]);
        end
        MODE[5:4] = 2'b00;
        tick(2);
        check("tog_to_pass", LED_BUS[2], 0);
        MODE[5:4] = 2'b11;
        tick(1);
        check("tog_restored", LED_BUS[2], 1);

        // BLINK on channel 3 and heartbeat
        PATTERN   = 8'b1010_0110;
        MODE[7:6] = 2'b10;
        SW[3]     = 1'b1;
        exp_q.push_back(4'b1000);
        tick(8);
        for (int k = 0; k < 40; k++) begin
            int ix;
            ix = ((n_rst - 1) >> 2) & 7;
            check($sformatf("led_user_c%0d", k), LED_USER, blink_seq[ix]);
            check($sformatf("blink3_c%0d", k), LED_BUS[3], blink_seq[ix]);
            tick(1);
        end

        // Reset in the middle of a debounce count
        SW[0] = 1'b0;
        exp_q.push_back(4'b0001);
        tick(12);
        SW[1] = 1'b1;
        tick(4);
        RST_N = 1'b0;
        #1;
        check("midrst_led_bus",   LED_BUS,   0);
        check("midrst_led_user",  LED_USER,  0);
        check("midrst_sw_stable", SW_STABLE, 0);
        check("midrst_sw_edge",   SW_EDGE,   0);
        tick(2);
        RST_N = 1'b1;
        start = cyc;
        exp_q.push_back(4'b1010);
        tick(4);
        check("postrst_not_early", SW_STABLE, 0);
        tick(2);
        check("postrst_stable", SW_STABLE, 4'b1010);
        check("postrst_edge_latency", edge_cyc - start, 5);
        check("postrst_tog_cleared", LED_BUS[2], 0);

        tick(10);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
